prio_encoder_pipe: RTL and testbench

PRIO_ENCODER_PIPE -- requirements
Module: prio_encoder_pipe

---
 rtl/prio_encoder_pipe.sv | 157 +++++++++++++++
 tb/tb_prio_encoder_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_pipe.sv
// Priority / one-hot encoder with a single registered valid/ready output stage
// and a saturating counter of accepted illegal request words.
module prio_encoder_pipe #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_hit,
    output logic             out_err,
    input  logic             err_clr,
    output logic [7:0]       err_count
);

    localparam logic [WIDTH-1:0] ZERO_VEC  = {WIDTH{1'b0}};
    localparam logic [OUT_W-1:0] ZERO_CODE = {OUT_W{1'b0}};

    // Highest set bit; later (higher) indices overwrite earlier ones.
    function automatic logic [OUT_W-1:0] msb_index(input logic [WIDTH-1:0] v);
        logic [OUT_W-1:0] idx;
        idx = ZERO_CODE;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                idx = OUT_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Lowest set bit; scan downwards so the lowest index is written last.
    function automatic logic [OUT_W-1:0] lsb_index(input logic [WIDTH-1:0] v);
        logic [OUT_W-1:0] idx;
        idx = ZERO_CODE;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = OUT_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic int ones(input logic [WIDTH-1:0] v);
        int c;
        c = 32'sd0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

    logic             accept_s;
    logic             drain_s;
    logic [OUT_W-1:0] code_s;
    logic             hit_s;
    logic             err_s;

    logic             out_valid_r;
    logic [OUT_W-1:0] out_r;
    logic             hit_r;
    logic             err_r;
    logic [7:0]       err_count_r;

    // Handshake qualifiers; in_ready looks through to out_ready so a full stage can stream.
    always_comb begin
        in_ready = !out_valid_r || out_ready;
        accept_s = in_valid && in_ready;
        drain_s  = out_valid_r && out_ready;
    end

    // Encode the incoming word according to MODE; a disabled word is a silent no-hit.
    always_comb begin
        code_s = ZERO_CODE;
        hit_s  = 1'b0;
        err_s  = 1'b0;
        if (!en) begin
            code_s = ZERO_CODE;
        end else begin
            case (MODE)
                32'sd1: begin
                    if (in != ZERO_VEC) begin
                        code_s = msb_index(in);
                        hit_s  = 1'b1;
                    end else begin
                        err_s  = 1'b1;
                    end
                end
                32'sd2: begin
                    if (in != ZERO_VEC) begin
                        code_s = lsb_index(in);
                        hit_s  = 1'b1;
                    end else begin
                        err_s  = 1'b1;
                    end
                end
                default: begin
                    if (ones(in) == 32'sd1) begin
                        code_s = lsb_index(in);
                        hit_s  = 1'b1;
                    end else begin
                        err_s  = 1'b1;
                    end
                end
            endcase
        end
    end

    // Output stage: load on accept, empty on drain-only, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_r       <= ZERO_CODE;
            hit_r       <= 1'b0;
            err_r       <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_r       <= code_s;
            hit_r       <= hit_s;
            err_r       <= err_s;
        end else if (drain_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating illegal-word counter; clear wins over a same-edge increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r <= 8'd0;
        end else if (err_clr) begin
            err_count_r <= 8'd0;
        end else if (accept_s && err_s && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'd1;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign out_hit   = hit_r;
    assign out_err   = err_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Directed, table-driven bench: one WIDTH=8 one-hot encoder plus WIDTH=12 MSB/LSB encoders.
module tb_prio_encoder_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8, MODE=0 instance
    logic       en8 = 1'b1, iv8 = 1'b0, ordy8 = 1'b1, clr8 = 1'b0;
    logic [7:0] in8 = 8'h00;
    logic       rdy8, ov8, hit8, err8;
    logic [2:0] o8;
    logic [7:0] cnt8;

    // WIDTH=12 instances, MODE=1 and MODE=2, shared stimulus
    logic        en12 = 1'b1, iv12 = 1'b0, ordy12 = 1'b1, clr12 = 1'b0;
    logic [11:0] in12 = 12'h000;
    logic        rdy_m1, ov_m1, hit_m1, err_m1, rdy_m2, ov_m2, hit_m2, err_m2;
    logic [3:0]  o_m1, o_m2;
    logic [7:0]  cnt_m1, cnt_m2;

    prio_encoder_pipe #(.WIDTH(8), .MODE(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .in_valid(iv8), .in_ready(rdy8), .in(in8),
        .out_valid(ov8), .out_ready(ordy8), .out(o8), .out_hit(hit8), .out_err(err8),
        .err_clr(clr8), .err_count(cnt8));

    prio_encoder_pipe #(.WIDTH(12), .MODE(1)) dut_m1 (
        .clk(clk), .rst_n(rst_n), .en(en12), .in_valid(iv12), .in_ready(rdy_m1), .in(in12),
        .out_valid(ov_m1), .out_ready(ordy12), .out(o_m1), .out_hit(hit_m1), .out_err(err_m1),
        .err_clr(clr12), .err_count(cnt_m1));

    prio_encoder_pipe #(.WIDTH(12), .MODE(2)) dut_m2 (
        .clk(clk), .rst_n(rst_n), .en(en12), .in_valid(iv12), .in_ready(rdy_m2), .in(in12),
        .out_valid(ov_m2), .out_ready(ordy12), .out(o_m2), .out_hit(hit_m2), .out_err(err_m2),
        .err_clr(clr12), .err_count(cnt_m2));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       en;
        logic [7:0] in;
        logic [2:0] out;
        logic       hit;
        logic       err;
    } vec8_t;

    typedef struct {
        logic [11:0] in;
        logic [3:0]  out_m1;
        logic [3:0]  out_m2;
        logic        hit;
    } vec12_t;

    vec8_t  t8[10];
    vec12_t t12[6];
    int     exp_cnt;

    initial begin
        t8[0] = '{1'b1, 8'h80, 3'd7, 1'b1, 1'b0};
        t8[1] = '{1'b1, 8'h01, 3'd0, 1'b1, 1'b0};
        t8[2] = '{1'b1, 8'h41, 3'd0, 1'b0, 1'b1};
        t8[3] = '{1'b1, 8'h00, 3'd0, 1'b0, 1'b1};
        t8[4] = '{1'b1, 8'h10, 3'd4, 1'b1, 1'b0};
        t8[5] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        t8[6] = '{1'b0, 8'h41, 3'd0, 1'b0, 1'b0};
        t8[7] = '{1'b1, 8'hFF, 3'd0, 1'b0, 1'b1};
        t8[8] = '{1'b1, 8'h20, 3'd5, 1'b1, 1'b0};
        t8[9] = '{1'b0, 8'h80, 3'd0, 1'b0, 1'b0};

        t12[0] = '{12'h824, 4'd11, 4'd2,  1'b1};
        t12[1] = '{12'h001, 4'd0,  4'd0,  1'b1};
        t12[2] = '{12'h800, 4'd11, 4'd11, 1'b1};
        t12[3] = '{12'h000, 4'd0,  4'd0,  1'b0};
        t12[4] = '{12'hFFF, 4'd11, 4'd0,  1'b1};
        t12[5] = '{12'h0A0, 4'd7,  4'd5,  1'b1};

        // Reset state, held asynchronously
        #12;
        chk("rst_ov8", ov8, 1'b0);
        chk("rst_out8", o8, 3'd0);
        chk("rst_hit8", hit8, 1'b0);
        chk("rst_err8", err8, 1'b0);
        chk("rst_cnt8", cnt8, 8'd0);
        chk("rst_rdy8", rdy8, 1'b1);
        chk("rst_ov_m1", ov_m1, 1'b0);
        chk("rst_ov_m2", ov_m2, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // MODE 0 table, back-to-back with out_ready=1
        exp_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            en8 = t8[k].en; in8 = t8[k].in; iv8 = 1'b1;
            @(posedge clk); #1;
            if (t8[k].err) exp_cnt++;
            chk($sformatf("t8[%0d]_valid", k), ov8, 1'b1);
            chk($sformatf("t8[%0d]_out", k), o8, t8[k].out);
            chk($sformatf("t8[%0d]_hit", k), hit8, t8[k].hit);
            chk($sformatf("t8[%0d]_err", k), err8, t8[k].err);
            chk($sformatf("t8[%0d]_cnt", k), cnt8, exp_cnt);
        end
        @(negedge clk) iv8 = 1'b0; en8 = 1'b1;
        @(posedge clk); #1;
        chk("drain_ov8", ov8, 1'b0);

        // MODE 1 vs MODE 2 at WIDTH=12
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in12 = t12[k].in; iv12 = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("t12[%0d]_m1_out", k), o_m1, t12[k].out_m1);
            chk($sformatf("t12[%0d]_m2_out", k), o_m2, t12[k].out_m2);
            chk($sformatf("t12[%0d]_m1_hit", k), hit_m1, t12[k].hit);
            chk($sformatf("t12[%0d]_m2_hit", k), hit_m2, t12[k].hit);
            chk($sformatf("t12[%0d]_m1_err", k), err_m1, !t12[k].hit);
            chk($sformatf("t12[%0d]_m2_valid", k), ov_m2, 1'b1);
        end
        @(negedge clk) iv12 = 1'b0;
        chk("m1_cnt", cnt_m1, 8'd1);
        chk("m2_cnt", cnt_m2, 8'd1);

        // Saturation of the illegal-word counter
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            in8 = 8'h41; iv8 = 1'b1;
            @(posedge clk);
        end
        #1;
        chk("sat_cnt", cnt8, 8'd255);
        chk("sat_err", err8, 1'b1);

        // Clear wins over a simultaneous illegal word
        @(negedge clk) clr8 = 1'b1; in8 = 8'h41;
        @(posedge clk); #1;
        chk("clr_cnt", cnt8, 8'd0);
        @(negedge clk) clr8 = 1'b0; iv8 = 1'b0;
        @(posedge clk); #1;
        chk("clr_hold", cnt8, 8'd0);

        // Backpressure: hold result 4 for three stalled cycles, then stream 0x02
        @(negedge clk) ordy8 = 1'b0; iv8 = 1'b1; in8 = 8'h10;
        @(posedge clk); #1;
        chk("stall_first_out", o8, 3'd4);
        chk("stall_first_ov", ov8, 1'b1);
        @(negedge clk) in8 = 8'h02;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_out", k), o8, 3'd4);
            chk($sformatf("stall%0d_ov", k), ov8, 1'b1);
            chk($sformatf("stall%0d_hit", k), hit8, 1'b1);
            chk($sformatf("stall%0d_rdy", k), rdy8, 1'b0);
        end
        @(negedge clk) ordy8 = 1'b1;
        #1;
        chk("unstall_rdy", rdy8, 1'b1);
        @(posedge clk); #1;
        chk("unstall_out", o8, 3'd1);
        chk("unstall_ov", ov8, 1'b1);
        @(negedge clk) iv8 = 1'b0;
        @(posedge clk); #1;
        chk("bubble_ov", ov8, 1'b0);

        // Async reset while a result is held
        @(negedge clk) iv8 = 1'b1; in8 = 8'h41;
        @(posedge clk); #1;
        chk("pre_rst_ov", ov8, 1'b1);
        chk("pre_rst_cnt", cnt8, 8'd1);
        #3 rst_n = 1'b0; iv8 = 1'b0;
        #1;
        chk("mid_rst_ov", ov8, 1'b0);
        chk("mid_rst_cnt", cnt8, 8'd0);
        chk("mid_rst_err", err8, 1'b0);
        chk("mid_rst_rdy", rdy8, 1'b1);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) iv8 = 1'b1; in8 = 8'h04;
        @(posedge clk); #1;
        chk("post_rst_out", o8, 3'd2);
        chk("post_rst_hit", hit8, 1'b1);
        chk("post_rst_ov", ov8, 1'b1);
        chk("post_rst_cnt", cnt8, 8'd0);
        @(negedge clk) iv8 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
